// File: rtl/alu_cmd_issuer.sv
// Command FIFO and issue FSM for the combinational main_ALU.
// Returns each ALU result to the host over a valid/ready channel.
module alu_cmd_issuer #(
  parameter int DATA_W = 2,
  parameter int OP_W   = 3,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [OP_W-1:0]            cmd_opcode,
  input  logic [DATA_W-1:0]          cmd_a,
  input  logic [DATA_W-1:0]          cmd_b,
  output logic [DATA_W-1:0]          alu_a,
  output logic [DATA_W-1:0]          alu_b,
  output logic [OP_W-1:0]            alu_opcode,
  input  logic [DATA_W-1:0]          alu_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [DATA_W-1:0]          res_data,
  output logic [OP_W-1:0]            res_opcode,
  output logic                       res_illegal,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [OP_W-1:0] OP_ILL = OP_W'(5);
  localparam logic [CW-1:0]   FULL   = CW'(DEPTH);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD
  } state_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          has_cmd;
  logic          push;
  logic          pop;
  logic          capture;
  logic          release_res;
  state_t        state;
  state_t        state_nx;

  // Ready depends only on occupancy, never on res_ready.
  assign cmd_ready  = !rst && (count < FULL);
  assign push       = cmd_valid && cmd_ready;
  assign has_cmd    = (count != '0);
  assign head       = mem[rd_ptr];
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state == IDLE: begin
        if (has_cmd) state_nx = ISSUE;
      end
      state == ISSUE: begin
        state_nx = HOLD;
      end
      state == HOLD: begin
        if (res_ready) state_nx = has_cmd ? ISSUE : IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    pop         = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    unique case (1'b1)
      state == IDLE: begin
        pop = has_cmd;
      end
      state == ISSUE: begin
        capture = 1'b1;
      end
      state == HOLD: begin
        release_res = res_ready;
        pop         = res_ready && has_cmd;
      end
      default: begin
        pop = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{op: cmd_opcode, a: cmd_a, b: cmd_b};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
    end else if (pop) begin
      alu_a      <= head.a;
      alu_b      <= head.b;
      alu_opcode <= head.op;
    end
  end

  // Illegal opcodes report zero regardless of what the ALU drives.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_opcode  <= '0;
      res_illegal <= 1'b0;
    end else if (capture) begin
      res_valid  <= 1'b1;
      res_opcode <= alu_opcode;
      if (alu_opcode >= OP_ILL) begin
        res_data    <= '0;
        res_illegal <= 1'b1;
      end else begin
        res_data    <= alu_out;
        res_illegal <= 1'b0;
      end
    end else if (release_res) begin
      res_valid <= 1'b0;
    end
  end

endmodule
